// File: rtl/param_reg_file.sv
// Parameterised register file: two combinational read ports, one write port, optional
// write-through bypass, optional hard-wired zero register and a sequential scrub engine.
module param_reg_file #(
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [WIDTH-1:0]  IN,
   input  logic [ADDR_W-1:0] INADDRESS,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] OUT1ADDRESS,
   input  logic [ADDR_W-1:0] OUT2ADDRESS,
   input  logic              CLEAR,
   output logic [WIDTH-1:0]  OUT1,
   output logic [WIDTH-1:0]  OUT2,
   output logic              BUSY,
   output logic              WRITE_DROP
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEARING} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [WIDTH-1:0]  regs_d [DEPTH];
   logic              drop_q, drop_d;
   logic              busy;
   logic              wr_en;
   logic              wr_fire;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (CLEAR) state_d = CLEARING;
         CLEARING: if (ptr_q == LAST_PTR) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == CLEARING);
   end

   // A write is accepted only when idle and not colliding with a scrub request;
   // writes to a hard-wired zero register are swallowed silently.
   assign wr_en   = WRITE && !busy && !CLEAR;
   assign wr_fire = wr_en && !((ZERO_REG != 0) && (INADDRESS == '0));
   assign drop_d  = WRITE && (busy || CLEAR);

   always_comb begin
      regs_d = regs_q;
      ptr_d  = ptr_q;
      if (busy) begin
         regs_d[ptr_q] = '0;
         ptr_d         = ptr_q + 1'b1;
      end else if (CLEAR) begin
         ptr_d = '0;
      end else if (wr_fire) begin
         regs_d[INADDRESS] = IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         ptr_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         ptr_q  <= ptr_d;
         drop_q <= drop_d;
      end
   end

   function automatic logic [WIDTH-1:0] rd_port(input logic [ADDR_W-1:0] addr);
      if ((ZERO_REG != 0) && (addr == '0))
         return '0;
      else if ((BYPASS != 0) && wr_fire && (addr == INADDRESS))
         return IN;
      else
         return regs_q[addr];
   endfunction

   assign OUT1       = rd_port(OUT1ADDRESS);
   assign OUT2       = rd_port(OUT2ADDRESS);
   assign BUSY       = busy;
   assign WRITE_DROP = drop_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: a default instance (a) and a BYPASS+ZERO_REG instance (b)
// share stimulus and are compared against an array-based reference model.
module tb_param_reg_file;

   logic       CLK = 1'b0;
   logic       RESET, WRITE, CLEAR;
   logic [7:0] IN;
   logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
   logic [7:0] a_out1, a_out2, b_out1, b_out2;
   logic       a_busy, a_drop, b_busy, b_drop;

   int tests = 0;
   int fails = 0;

   // Reference model: register contents, scrub progress, expected drop pulse
   logic [7:0] mem [8];
   bit         m_busy;
   int         m_idx;
   bit         m_drop;

   always #5 CLK = ~CLK;

   param_reg_file #(.WIDTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_a (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR),
      .OUT1(a_out1), .OUT2(a_out2), .BUSY(a_busy), .WRITE_DROP(a_drop));

   param_reg_file #(.WIDTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_b (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR),
      .OUT1(b_out1), .OUT2(b_out2), .BUSY(b_busy), .WRITE_DROP(b_drop));

   function automatic logic [7:0] exp_a(input logic [2:0] addr);
      return mem[addr];
   endfunction

   function automatic logic [7:0] exp_b(input logic [2:0] addr);
      if (addr == 3'd0) return 8'h00;
      if (WRITE && !m_busy && !CLEAR && addr == INADDRESS) return IN;
      return mem[addr];
   endfunction

   // Advance one clock, applying the behavioural rules to the model with pre-edge inputs.
   task automatic tick();
      bit         r = RESET, c = CLEAR, w = WRITE;
      logic [2:0] wa = INADDRESS;
      logic [7:0] wd = IN;
      @(posedge CLK);
      if (r) begin
         for (int i = 0; i < 8; i++) mem[i] = 8'h00;
         m_busy = 0; m_idx = 0; m_drop = 0;
      end else begin
         m_drop = w && (m_busy || c);
         if (m_busy) begin
            mem[m_idx] = 8'h00;
            m_idx++;
            if (m_idx == 8) begin m_busy = 0; m_idx = 0; end
         end else if (c) begin
            m_busy = 1; m_idx = 0;
         end else if (w) begin
            mem[wa] = wd;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      RESET = 1; WRITE = 1; CLEAR = 1; IN = 8'hEE; INADDRESS = 3'd2;
      tick(); tick();
      RESET = 0; WRITE = 0; CLEAR = 0;
      #1;
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", a_busy); end
      tests++; if (a_drop !== 1'b0 || b_drop !== 1'b0) begin fails++; $display("FAIL reset_drop got %b/%b exp 0", a_drop, b_drop); end
      for (int i = 0; i < 8; i += 2) begin
         OUT1ADDRESS = 3'(i); OUT2ADDRESS = 3'(i + 1); #1;
         tests++;
         if (a_out1 !== 8'h00 || a_out2 !== 8'h00 || b_out1 !== 8'h00 || b_out2 !== 8'h00) begin
            fails++; $display("FAIL reset_read addr %0d got %h %h %h %h exp 00", i, a_out1, a_out2, b_out1, b_out2);
         end
      end
   endtask

   task automatic test_basic_write();
      WRITE = 1; INADDRESS = 3'd3; IN = 8'h2A; OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd4;
      tick();
      WRITE = 0; #1;
      tests++; if (a_out1 !== 8'h2A) begin fails++; $display("FAIL write_r3 got %h exp 2a", a_out1); end
      tests++; if (a_out2 !== 8'h00) begin fails++; $display("FAIL read_r4 got %h exp 00", a_out2); end
      tests++; if (b_out1 !== 8'h2A) begin fails++; $display("FAIL write_r3_b got %h exp 2a", b_out1); end
   endtask

   task automatic test_bypass();
      WRITE = 1; INADDRESS = 3'd5; IN = 8'h77; OUT2ADDRESS = 3'd5; #1;
      tests++; if (b_out2 !== 8'h77) begin fails++; $display("FAIL bypass_fwd got %h exp 77", b_out2); end
      tests++; if (a_out2 !== 8'h00) begin fails++; $display("FAIL no_bypass_old got %h exp 00", a_out2); end
      tick();
      WRITE = 0; #1;
      tests++; if (a_out2 !== 8'h77) begin fails++; $display("FAIL no_bypass_after got %h exp 77", a_out2); end
   endtask

   task automatic test_zero_reg();
      WRITE = 1; INADDRESS = 3'd0; IN = 8'hFF; OUT1ADDRESS = 3'd0; #1;
      tests++; if (b_out1 !== 8'h00) begin fails++; $display("FAIL zero_no_bypass got %h exp 00", b_out1); end
      tick();
      WRITE = 0; #1;
      tests++; if (b_out1 !== 8'h00) begin fails++; $display("FAIL zero_read got %h exp 00", b_out1); end
      tests++; if (b_drop !== 1'b0) begin fails++; $display("FAIL zero_drop got %b exp 0", b_drop); end
      tests++; if (a_out1 !== 8'hFF) begin fails++; $display("FAIL r0_normal got %h exp ff", a_out1); end
   endtask

   task automatic test_scrub();
      int n = 0;
      for (int i = 0; i < 8; i++) begin
         WRITE = 1; INADDRESS = 3'(i); IN = 8'(i + 1); tick();
      end
      WRITE = 0; CLEAR = 1; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd3;
      tick();
      CLEAR = 0; #1;
      while (a_busy && n < 20) begin
         n++;
         if (n == 4) begin
            tests++; if (a_out1 !== 8'h00) begin fails++; $display("FAIL scrub_r2 got %h exp 00", a_out1); end
            tests++; if (a_out2 !== 8'h04) begin fails++; $display("FAIL scrub_r3 got %h exp 04", a_out2); end
         end
         tick();
      end
      tests++; if (n != 8) begin fails++; $display("FAIL scrub_busy_len got %0d exp 8", n); end
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i); #1;
         tests++; if (a_out1 !== 8'h00) begin fails++; $display("FAIL scrub_done r%0d got %h exp 00", i, a_out1); end
      end
   endtask

   task automatic test_write_drop();
      int n = 0;
      CLEAR = 1; tick(); CLEAR = 0; tick();
      WRITE = 1; INADDRESS = 3'd6; IN = 8'h55; tick();
      WRITE = 0; #1;
      tests++; if (a_drop !== 1'b1 || b_drop !== 1'b1) begin fails++; $display("FAIL busy_drop got %b/%b exp 1", a_drop, b_drop); end
      tick();
      tests++; if (a_drop !== 1'b0) begin fails++; $display("FAIL drop_pulse got %b exp 0", a_drop); end
      while (a_busy && n < 20) begin n++; tick(); end
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL drop_scrub_end busy got %b exp 0", a_busy); end
      OUT1ADDRESS = 3'd6; #1;
      tests++; if (a_out1 !== 8'h00) begin fails++; $display("FAIL busy_write_r6 got %h exp 00", a_out1); end
      CLEAR = 1; WRITE = 1; INADDRESS = 3'd2; IN = 8'h99; tick();
      CLEAR = 0; WRITE = 0; #1;
      tests++; if (a_drop !== 1'b1 || a_busy !== 1'b1) begin fails++; $display("FAIL clear_write drop/busy got %b/%b exp 1/1", a_drop, a_busy); end
      n = 0;
      while (a_busy && n < 20) begin n++; tick(); end
      OUT1ADDRESS = 3'd2; #1;
      tests++; if (a_out1 !== 8'h00) begin fails++; $display("FAIL clear_write_r2 got %h exp 00", a_out1); end
   endtask

   task automatic test_reset_mid_scrub();
      for (int i = 0; i < 8; i++) begin
         WRITE = 1; INADDRESS = 3'(i); IN = 8'(8'hA0 + i); tick();
      end
      WRITE = 0; CLEAR = 1; tick(); CLEAR = 0;
      tick(); tick(); tick();
      RESET = 1; tick(); RESET = 0; #1;
      tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", a_busy); end
      for (int i = 0; i < 8; i++) begin
         OUT1ADDRESS = 3'(i); #1;
         tests++; if (a_out1 !== 8'h00) begin fails++; $display("FAIL abort_r%0d got %h exp 00", i, a_out1); end
      end
      WRITE = 1; INADDRESS = 3'd1; IN = 8'h11; OUT1ADDRESS = 3'd1; tick();
      WRITE = 0; #1;
      tests++; if (a_out1 !== 8'h11) begin fails++; $display("FAIL post_abort_write got %h exp 11", a_out1); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         RESET       = ($urandom_range(99) < 2);
         CLEAR       = ($urandom_range(99) < 5);
         WRITE       = ($urandom_range(99) < 60);
         IN          = 8'($urandom);
         INADDRESS   = 3'($urandom);
         OUT1ADDRESS = 3'($urandom);
         OUT2ADDRESS = ($urandom_range(3) == 0) ? INADDRESS : 3'($urandom);
         #1;
         tests++;
         if (a_out1 !== exp_a(OUT1ADDRESS) || a_out2 !== exp_a(OUT2ADDRESS)) begin
            fails++; $display("FAIL rand_a cyc %0d got %h %h exp %h %h", c, a_out1, a_out2, exp_a(OUT1ADDRESS), exp_a(OUT2ADDRESS));
         end
         tests++;
         if (b_out1 !== exp_b(OUT1ADDRESS) || b_out2 !== exp_b(OUT2ADDRESS)) begin
            fails++; $display("FAIL rand_b cyc %0d got %h %h exp %h %h", c, b_out1, b_out2, exp_b(OUT1ADDRESS), exp_b(OUT2ADDRESS));
         end
         tests++;
         if (a_busy !== m_busy || b_busy !== m_busy || a_drop !== m_drop || b_drop !== m_drop) begin
            fails++; $display("FAIL rand_ctl cyc %0d busy %b/%b drop %b/%b exp busy %b drop %b", c, a_busy, b_busy, a_drop, b_drop, m_busy, m_drop);
         end
         tick();
      end
      RESET = 0; CLEAR = 0; WRITE = 0;
   endtask

   initial begin
      RESET = 0; WRITE = 0; CLEAR = 0; IN = '0;
      INADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      m_busy = 0; m_idx = 0; m_drop = 0;
      #1;
      test_reset();
      test_basic_write();
      test_bypass();
      test_zero_reg();
      test_scrub();
      test_write_drop();
      test_reset_mid_scrub();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_reg_file.md
PARAM_REG_FILE -- requirements
Module: param_reg_file

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each register and data port, legal 1..64.
REQ-002 Parameter ADDR_W, default 3, address width; register count DEPTH = 2**ADDR_W, legal ADDR_W 1..6.
REQ-003 Parameter BYPASS, default 0; 1 = same-cycle write data forwarded to matching read ports.
REQ-004 Parameter ZERO_REG, default 0; 1 = register 0 reads as zero and ignores writes.
REQ-005 CLK  input  1  single clock, all state updates on rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset, sampled on rising CLK edge.
REQ-007 IN  input  WIDTH  write data.
REQ-008 INADDRESS  input  ADDR_W  write address.
REQ-009 WRITE  input  1  write enable.
REQ-010 OUT1ADDRESS  input  ADDR_W  read port 1 address.
REQ-011 OUT2ADDRESS  input  ADDR_W  read port 2 address.
REQ-012 CLEAR  input  1  request a sequential scrub of all registers to zero.
REQ-013 OUT1  output  WIDTH  read port 1 data.
REQ-014 OUT2  output  WIDTH  read port 2 data.
REQ-015 BUSY  output  1  high while the scrub is in progress.
REQ-016 WRITE_DROP  output  1  registered one-cycle pulse when a requested write was discarded.

Function
REQ-017 Read ports shall be combinational: OUTn = registers[OUTnADDRESS], no clock latency; no simulation delays in RTL.
REQ-018 With WRITE=1, BUSY=0, CLEAR=0, RESET=0, registers[INADDRESS] shall take IN at the rising edge; visible on reads the same cycle after that edge.
REQ-019 BYPASS=1: when WRITE=1, BUSY=0, CLEAR=0 and OUTnADDRESS==INADDRESS, OUTn shall equal IN combinationally before the edge; BYPASS=0: OUTn shows old contents until the edge.
REQ-020 ZERO_REG=1: reads of address 0 shall return 0; writes to address 0 shall be silently ignored (no WRITE_DROP), bypass shall not forward to address 0.
REQ-021 Scrub FSM states: IDLE, CLEARING; pointer PTR of ADDR_W bits.
REQ-022 IDLE with CLEAR=1 at an edge -> CLEARING, PTR=0, BUSY=1 from next cycle.
REQ-023 In CLEARING each edge shall zero registers[PTR] and increment PTR; at PTR==DEPTH-1 zero it and return to IDLE; scrub occupies exactly DEPTH cycles with BUSY=1.
REQ-024 CLEAR asserted during CLEARING shall be ignored (no restart).
REQ-025 Any WRITE=1 while BUSY=1, or coincident with CLEAR=1 in IDLE, shall be discarded and WRITE_DROP=1 the following cycle; CLEAR has priority.
REQ-026 Reads during CLEARING return current contents: 0 for addresses < PTR, old data otherwise.
REQ-027 WRITE_DROP shall be 0 in every cycle not covered by REQ-025.

Reset
REQ-028 RESET=1 at an edge shall zero all registers, force IDLE, PTR=0, BUSY=0, WRITE_DROP=0, overriding WRITE and CLEAR the same edge.
REQ-029 RESET during CLEARING shall abort the scrub; next cycle BUSY=0 and all registers 0.
REQ-030 After reset, OUT1=OUT2=0 for any address.

Verification
REQ-031 Defaults; reset; write 8'h2A to r3; OUT1ADDRESS=3 -> OUT1=8'h2A the cycle after the edge, OUT2 (addr 4)=0.
REQ-032 BYPASS=1: WRITE r5=8'h77, OUT2ADDRESS=5 same cycle -> OUT2=8'h77 before the edge; BYPASS=0 -> old value 8'h00 until the edge.
REQ-033 ZERO_REG=1: write r0=8'hFF -> OUT1ADDRESS=0 reads 0, WRITE_DROP stays 0.
REQ-034 Fill r0..r7 with 1..8, pulse CLEAR -> BUSY high exactly 8 cycles; after 3 scrub edges r0..r2=0, r3=4; then all 0, BUSY=0.
REQ-035 WRITE r6=8'h55 during BUSY -> r6 stays/ends 0, WRITE_DROP pulses one cycle; CLEAR+WRITE same edge in IDLE -> write dropped, WRITE_DROP=1.
REQ-036 RESET mid-scrub at cycle 4 -> BUSY=0 next cycle, all registers 0, subsequent write r1=8'h11 succeeds.
